// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard-side game controller.
// Scan codes, the PS/2 receiver state encoding and the decoded key event record.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DECODE} rx_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/kbd_game_ctrl_if.sv
// Key event port: one registered event offered under valid/ready.
// master = event producer (controller), slave = consumer (game FSM).
interface kbd_game_ctrl_if;

    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_brk;
    logic       key_ext;

    modport master (output key_valid, key_code, key_brk, key_ext, input key_ready);
    modport slave  (input key_valid, key_code, key_brk, key_ext, output key_ready);

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw pins, finds PS2_clk falling edges and
// deframes start/8 data/parity/stop with a per-bit watchdog.
// Emits rx_byte with a one-cycle byte_valid, plus frame_err and timeout pulses.
// Build option: KBD_PARITY_CHECK_EN enables odd-parity checking of each frame.
module ps2_frame_rx
    import kbd_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       timeout
);

    localparam longint WD_CYC = longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ) / longint'(1_000_000);
    localparam int     WD_W   = $clog2(WD_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_CYC);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_q;
    logic                   fall, din;

    rx_state_t              state_q, state_d;
    logic [7:0]             sr;
    logic [2:0]             bit_cnt;
    logic [WD_W-1:0]        wd_cnt;
    logic                   wd_on, wd_exp, err_d;

    // Synchronisers idle high so a line held high at reset release gives no false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_q    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_q    <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall = clk_q & ~clk_sync[SYNC_STAGES-1];
    assign din  = dat_sync[SYNC_STAGES-1];

    // Watchdog only runs while a frame is in flight and expires after WD_LIM quiet cycles.
    assign wd_on  = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
    assign wd_exp = wd_on && !fall && (wd_cnt == WD_LIM - 1'b1);

    // Rx state register plus registered error/timeout pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_err <= err_d;
            timeout   <= wd_exp;
        end
    end

    // Next-state: one transition per PS2_clk fall; watchdog expiry overrides everything.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!din) state_d = DATA;
                    else      err_d   = 1'b1;
                end
            end
            DATA: begin
                if (fall && bit_cnt == 3'd7) state_d = PARITY;
            end
            PARITY: begin
                if (fall) begin
`ifdef KBD_PARITY_CHECK_EN
                    if (odd_parity_ok(sr, din)) begin
                        state_d = STOP;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
`else
                    state_d = STOP;
`endif
                end
            end
            STOP: begin
                if (fall) begin
                    if (din) begin
                        state_d = DECODE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            DECODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wd_exp) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    // Shift register (LSB first), bit counter and watchdog counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            wd_cnt  <= '0;
        end else begin
            if (state_q == IDLE) begin
                bit_cnt <= '0;
            end else if (state_q == DATA && fall) begin
                sr      <= {din, sr[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (!wd_on || fall) wd_cnt <= '0;
            else                wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign rx_byte    = sr;
    assign byte_valid = (state_q == DECODE);

endmodule

// File: rtl/kbd_game_ctrl.sv
// Keyboard-side game controller: PS/2 deframing, F0/E0 prefix tracking, one flap
// pulse per space press, pause toggle on Esc, and a one-entry valid/ready key event port.
// Build option: KBD_PARITY_CHECK_EN (passed through to ps2_frame_rx) checks frame parity.
module kbd_game_ctrl
    import kbd_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 50_000_000,
    parameter int         TIMEOUT_US  = 2000,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FLAP_CODE   = SC_SPACE,
    parameter logic [7:0] PAUSE_CODE  = SC_ESC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PS2_clk,
    input  logic            PS2_data,
    output logic            flap,
    output logic            pause,
    output logic            frame_err,
    output logic            evt_drop,
    kbd_game_ctrl_if.master kif
);

    logic [7:0] rx_byte;
    logic       rx_vld, rx_tmo;
    logic       brk_f, ext_f;
    logic       flap_held, pause_held;
    logic       emit, flap_hit, pause_hit;
    logic       key_vld;
    key_evt_t   evt, out_q;

    ps2_frame_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (PS2_clk),
        .ps2_data   (PS2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_vld),
        .frame_err  (frame_err),
        .timeout    (rx_tmo)
    );

    // A byte that is not a prefix completes an event carrying the prefixes seen so far.
    assign emit      = rx_vld && (rx_byte != SC_BREAK) && (rx_byte != SC_EXT);
    assign evt       = {ext_f, brk_f, rx_byte};
    assign flap_hit  = emit && !ext_f && (rx_byte == FLAP_CODE);
    assign pause_hit = emit && !ext_f && (rx_byte == PAUSE_CODE);

    // Prefix flags: set by F0/E0, cleared once the event is emitted or a frame times out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_f <= 1'b0;
            ext_f <= 1'b0;
        end else if (rx_tmo) begin
            brk_f <= 1'b0;
            ext_f <= 1'b0;
        end else if (rx_vld) begin
            if (rx_byte == SC_BREAK) begin
                brk_f <= 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_f <= 1'b1;
            end else begin
                brk_f <= 1'b0;
                ext_f <= 1'b0;
            end
        end
    end

    // Flap: pulse on the first make only; typematic repeats are ignored until release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flap      <= 1'b0;
            flap_held <= 1'b0;
        end else begin
            flap <= 1'b0;
            if (flap_hit) begin
                if (brk_f) begin
                    flap_held <= 1'b0;
                end else if (!flap_held) begin
                    flap      <= 1'b1;
                    flap_held <= 1'b1;
                end
            end
        end
    end

    // Pause: same held qualification, toggling a level instead of pulsing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause      <= 1'b0;
            pause_held <= 1'b0;
        end else if (pause_hit) begin
            if (brk_f) begin
                pause_held <= 1'b0;
            end else if (!pause_held) begin
                pause      <= ~pause;
                pause_held <= 1'b1;
            end
        end
    end

    // One-entry output register; a new event while the entry is stalled is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_vld  <= 1'b0;
            out_q    <= '0;
            evt_drop <= 1'b0;
        end else begin
            evt_drop <= 1'b0;
            if (emit) begin
                if (!key_vld || kif.key_ready) begin
                    out_q   <= evt;
                    key_vld <= 1'b1;
                end else begin
                    evt_drop <= 1'b1;
                end
            end else if (kif.key_ready) begin
                key_vld <= 1'b0;
            end
        end
    end

    assign kif.key_valid = key_vld;
    assign kif.key_code  = out_q.code;
    assign kif.key_brk   = out_q.brk;
    assign kif.key_ext   = out_q.ext;

endmodule

// File: tb/tb_kbd_game_ctrl.sv
// Self-checking bench for kbd_game_ctrl: directed PS/2 frames plus a randomized
// byte/back-pressure phase, checked against a scan-code level reference model.
module tb_kbd_game_ctrl;

    localparam int CF = 1_000_000;
    localparam int TO = 2000;
    localparam int HP = 30;   // PS/2 half period in clk cycles

    logic clk = 1'b0, rst = 1'b0, PS2_clk = 1'b1, PS2_data = 1'b1;
    logic flap, pause, frame_err, evt_drop;

    kbd_game_ctrl_if kif();

    kbd_game_ctrl #(.CLK_FREQ_HZ(CF), .TIMEOUT_US(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .PS2_clk   (PS2_clk),
        .PS2_data  (PS2_data),
        .flap      (flap),
        .pause     (pause),
        .frame_err (frame_err),
        .evt_drop  (evt_drop),
        .kif       (kif)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int flap_cnt = 0, ferr_cnt = 0, drop_cnt = 0;
    int exp_flap = 0, exp_ferr = 0, exp_drop = 0;
    logic [9:0] got_q[$], exp_q[$];
    logic m_brk, m_ext, m_fheld, m_pheld, m_pause;
    logic rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_fheld = 0; m_pheld = 0; m_pause = 0;
    endtask

    // Scan-code level behaviour of the keyboard controller.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            exp_q.push_back({m_ext, m_brk, b});
            if (!m_ext && b == 8'h29) begin
                if (m_brk) m_fheld = 0;
                else if (!m_fheld) begin exp_flap++; m_fheld = 1; end
            end
            if (!m_ext && b == 8'h76) begin
                if (m_brk) m_pheld = 0;
                else if (!m_pheld) begin m_pause = ~m_pause; m_pheld = 1; end
            end
            m_brk = 0; m_ext = 0;
        end
    endtask

    // Drive the first n bits of frame f (bit 0 = start) as the keyboard would.
    task automatic send_raw(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_data = f[i];
            if (rnd_rdy) kif.key_ready = 1'($urandom_range(0, 1));
            wt(HP);
            PS2_clk = 1'b0;
            if (rnd_rdy) kif.key_ready = 1'($urandom_range(0, 1));
            wt(HP);
            PS2_clk = 1'b1;
        end
        PS2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit mdl);
        send_raw({1'b1, ~^b, b, 1'b0}, 11);
        if (rnd_rdy) kif.key_ready = 1'b1;
        wt(2 * HP);
        if (mdl) model_byte(b);
    endtask

    task automatic check_all(input string t);
        chk({t, "_flap"}, 32'(flap_cnt), 32'(exp_flap));
        chk({t, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
        chk({t, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
        chk({t, "_pause"}, 32'(pause), 32'(m_pause));
        chk({t, "_nevt"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({t, "_evt"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    // Monitor: count pulses, capture accepted events, and check a stalled event holds still.
    logic pv = 1'b0, pr = 1'b0;
    logic [9:0] pd = '0;
    always @(negedge clk) begin
        logic [9:0] cur;
        cur = {kif.key_ext, kif.key_brk, kif.key_code};
        if (!rst) begin
            pv = 1'b0;
        end else begin
            if (flap) flap_cnt++;
            if (frame_err) ferr_cnt++;
            if (evt_drop) drop_cnt++;
            if (pv && !pr) begin
                chk("hold_valid", 32'(kif.key_valid), 32'd1);
                chk("hold_data", 32'(cur), 32'(pd));
            end
            if (kif.key_valid && kif.key_ready) got_q.push_back(cur);
            pv = kif.key_valid;
            pr = kif.key_ready;
            pd = cur;
        end
    end

    initial begin
        kif.key_ready = 1'b1;
        model_reset();
        wt(3);
        chk("rst_flap", 32'(flap), 0);
        chk("rst_pause", 32'(pause), 0);
        chk("rst_valid", 32'(kif.key_valid), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_drop", 32'(evt_drop), 0);
        rst = 1'b1;
        wt(5);

        // Typematic repeat then release: one flap.
        send(8'h29, 1); send(8'h29, 1); send(8'hF0, 1); send(8'h29, 1);
        check_all("flap");

        // Pause toggles only on qualifying makes.
        send(8'h76, 1); chk("pause1", 32'(pause), 1);
        send(8'hF0, 1); send(8'h76, 1); chk("pause2", 32'(pause), 1);
        send(8'h76, 1); chk("pause3", 32'(pause), 0);
        check_all("pause");

        // Extended 29 is not flap.
        send(8'hE0, 1); send(8'h29, 1);
        check_all("ext");

        // Bad stop bit, then a good frame.
        send_raw({1'b0, ~^8'h29, 8'h29, 1'b0}, 11);
        wt(2 * HP);
        exp_ferr++;
        send(8'h29, 1);
        check_all("stop");

        // Bad start bit.
        send_raw(11'h7FF, 1);
        wt(2 * HP);
        exp_ferr++;
        check_all("start");

        // Watchdog: partial frame after F0 discards the prefix.
        send(8'hF0, 1);
        send_raw({1'b1, 1'b0, 8'h76, 1'b0}, 5);
        wt(TO + 500);
        exp_ferr++;
        m_brk = 0; m_ext = 0;
        send(8'h1C, 1);
        send_raw({1'b1, 1'b0, 8'h76, 1'b0}, 5);
        wt(TO + 500);
        exp_ferr++;
        send(8'h76, 1);
        check_all("wdog");

        // Back-pressure: second event dropped, first held.
        kif.key_ready = 1'b0;
        send(8'h1C, 1);
        send(8'h32, 0);
        exp_drop++;
        chk("drop_valid", 32'(kif.key_valid), 1);
        chk("drop_code", 32'(kif.key_code), 32'h1C);
        kif.key_ready = 1'b1;
        wt(4);
        chk("drop_clear", 32'(kif.key_valid), 0);
        check_all("drop");

        // Parity error behaviour depends on the build option.
        send(8'hF0, 1); send(8'h29, 1);
        send_raw({1'b1, ^8'h29, 8'h29, 1'b0}, 11);
        wt(2 * HP);
`ifdef KBD_PARITY_CHECK_EN
        exp_ferr++;
`else
        model_byte(8'h29);
`endif
        send(8'hF0, 1); send(8'h29, 1);
        check_all("parity");

        // Randomized bytes with random back-pressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 14; i++) begin
            logic [7:0] b;
            case ($urandom_range(0, 7))
                0: b = 8'h29;
                1: b = 8'h76;
                2: b = 8'hF0;
                3: b = 8'hE0;
                4: b = 8'h1C;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send(b, 1);
            if (i % 4 == 3) check_all("rnd");
        end
        rnd_rdy = 1'b0;
        kif.key_ready = 1'b1;
        send(8'hF0, 1); send(8'h29, 1);
        check_all("rnd_end");

        // Reset mid-frame.
        if (!m_pause) send(8'h76, 1);
        check_all("pre_rst");
        send_raw({1'b1, ~^8'h29, 8'h29, 1'b0}, 4);
        rst = 1'b0;
        #1;
        chk("mid_rst_pause", 32'(pause), 0);
        chk("mid_rst_valid", 32'(kif.key_valid), 0);
        chk("mid_rst_flap", 32'(flap), 0);
        wt(3);
        PS2_data = 1'b1;
        rst = 1'b1;
        model_reset();
        wt(10);
        send(8'h29, 1);
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
